// File: rtl/router_pkg.sv
// Shared constants for the 1x3 router.
// Holds the default datapath sizes, the header field slices
// ({len[7:2], addr[1:0]}), the packet counter width and the output port
// addresses.
package router_pkg;

  localparam int DATA_W    = 8;
  localparam int DEPTH     = 16;
  localparam int ADDR_W    = 4;

  // Header byte layout
  localparam int LEN_MSB   = 7;
  localparam int LEN_LSB   = 2;
  localparam int ADDR_MSB  = 1;
  localparam int ADDR_LSB  = 0;

  // Wide enough to hold the largest length plus one for the parity byte
  localparam int PKT_CNT_W = 7;

  localparam logic [1:0] ADDR_P0 = 2'b00;
  localparam logic [1:0] ADDR_P1 = 2'b01;
  localparam logic [1:0] ADDR_P2 = 2'b10;

endpackage

// File: rtl/router_fifo.sv
// Per-destination packet FIFO of the 1x3 router (one instance per port).
// Each stored word carries an lfd tag marking a header byte. On read, the
// header's length loads a packet counter so that data_out drops back to 0
// once the last byte (the parity) of a packet has been consumed.
// Ports:
//   clk, resetn     rising-edge clock, synchronous active-low reset
//   soft_reset      synchronous flush (synchronizer timeout)
//   write_enb       write request; lfd_state tags data_in as a header
//   read_enb        read request from the destination client
//   data_out        registered read data, valid one clock after the read
//   full, empty     combinational status from the pointers
module router_fifo #(
  parameter int DATA_W = router_pkg::DATA_W,
  parameter int DEPTH  = router_pkg::DEPTH,
  parameter int ADDR_W = router_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              soft_reset,
  input  logic              write_enb,
  input  logic              read_enb,
  input  logic              lfd_state,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              full,
  output logic              empty
);
  import router_pkg::*;

  // Extra MSB on each pointer separates full from empty after a wrap
  logic [ADDR_W:0]        wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]        rd_ptr_q, rd_ptr_d;
  logic [PKT_CNT_W-1:0]   pkt_cnt_q, pkt_cnt_d;
  logic [DATA_W-1:0]      data_out_q, data_out_d;
  logic [DATA_W:0]        mem_q [DEPTH];
  logic [DATA_W:0]        rd_word;
  logic                   do_wr, do_rd;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                 (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);

  assign rd_word  = mem_q[rd_ptr_q[ADDR_W-1:0]];
  assign data_out = data_out_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    pkt_cnt_d  = pkt_cnt_q;
    data_out_d = data_out_q;
    // Flush and reset take precedence in the register block; gating here
    // also keeps the memory from being written during either.
    do_wr = resetn && !soft_reset && write_enb && !full;
    do_rd = resetn && !soft_reset && read_enb  && !empty;

    if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;

    if (do_rd) begin
      rd_ptr_d   = rd_ptr_q + 1'b1;
      data_out_d = rd_word[DATA_W-1:0];
      if (rd_word[DATA_W])
        // Payload bytes plus the trailing parity byte
        pkt_cnt_d = PKT_CNT_W'(rd_word[LEN_MSB:LEN_LSB]) + PKT_CNT_W'(1);
      else if (pkt_cnt_q != '0)
        pkt_cnt_d = pkt_cnt_q - 1'b1;
    end else if (pkt_cnt_q == '0) begin
      // Packet fully delivered: return the bus to idle
      data_out_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      pkt_cnt_q  <= '0;
      data_out_q <= '0;
    end else if (soft_reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      pkt_cnt_q  <= '0;
      data_out_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      pkt_cnt_q  <= pkt_cnt_d;
      data_out_q <= data_out_d;
    end
  end

  // Storage is deliberately not cleared by either reset
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[ADDR_W-1:0]] <= {lfd_state, data_in};
  end

endmodule

// File: tb/tb_router_fifo.sv
module tb_router_fifo;
  logic       clk = 1'b0;
  logic       resetn, soft_reset, write_enb, read_enb, lfd_state;
  logic [7:0] data_in, data_out;
  logic       full, empty;

  int nvec = 0;
  int nerr = 0;

  router_fifo dut (
    .clk(clk), .resetn(resetn), .soft_reset(soft_reset),
    .write_enb(write_enb), .read_enb(read_enb), .lfd_state(lfd_state),
    .data_in(data_in), .data_out(data_out), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  // Advance one rising edge, then settle so outputs are sampled off-edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] d, input logic lfd);
    write_enb = 1'b1; lfd_state = lfd; data_in = d;
    step();
    write_enb = 1'b0; lfd_state = 1'b0;
  endtask

  initial begin
    logic [7:0] pkt [5];
    resetn = 1'b0; soft_reset = 1'b0; write_enb = 1'b0; read_enb = 1'b0;
    lfd_state = 1'b0; data_in = '0;
    step(); step();
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_dout", data_out, 0);
    resetn = 1'b1;
    step();

    // 1: header 0C (len 3), three payload bytes, parity, then read out
    pkt[0] = 8'h0C; pkt[1] = 8'h11; pkt[2] = 8'h22; pkt[3] = 8'h33; pkt[4] = 8'h44;
    wr(pkt[0], 1'b1);
    for (int i = 1; i < 5; i++) wr(pkt[i], 1'b0);
    chk("t1_not_empty", empty, 0);
    read_enb = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("t1_rd%0d", i), data_out, pkt[i]);
    end
    read_enb = 1'b0;
    step();
    chk("t1_dout_idle", data_out, 0);
    chk("t1_empty", empty, 1);

    // 2: fill, overflow write dropped, drain in order
    for (int i = 0; i < 16; i++) begin
      wr(8'h10 + 8'(i), 1'b0);
      chk($sformatf("t2_full%0d", i), full, (i == 15) ? 1 : 0);
    end
    wr(8'hAA, 1'b0);
    chk("t2_full_after_drop", full, 1);
    chk("t2_not_empty", empty, 0);
    read_enb = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      chk($sformatf("t2_rd%0d", i), data_out, 8'h10 + 8'(i));
    end
    read_enb = 1'b0;
    chk("t2_empty", empty, 1);
    step();
    chk("t2_dout_idle", data_out, 0);

    // 3: simultaneous read+write when full, then when empty
    for (int i = 0; i < 16; i++) wr(8'h20 + 8'(i), 1'b0);
    chk("t3_full", full, 1);
    write_enb = 1'b1; read_enb = 1'b1; data_in = 8'h77;
    step();
    write_enb = 1'b0;
    chk("t3_rw_full_dout", data_out, 8'h20);
    chk("t3_rw_full_notfull", full, 0);
    for (int i = 1; i < 16; i++) begin
      step();
      chk($sformatf("t3_rd%0d", i), data_out, 8'h20 + 8'(i));
    end
    read_enb = 1'b0;
    chk("t3_drained", empty, 1);
    step();
    write_enb = 1'b1; read_enb = 1'b1; data_in = 8'h66;
    step();
    write_enb = 1'b0; read_enb = 1'b0;
    chk("t3_rw_empty_dout", data_out, 0);
    chk("t3_rw_empty_notempty", empty, 0);
    chk("t3_rw_empty_full", full, 0);
    read_enb = 1'b1;
    step();
    read_enb = 1'b0;
    chk("t3_rd66", data_out, 8'h66);
    chk("t3_empty_end", empty, 1);

    // 4: 40 concurrent write/read pairs with one entry in flight
    wr(8'h80, 1'b0);
    for (int i = 0; i < 40; i++) begin
      write_enb = 1'b1; read_enb = 1'b1; data_in = 8'h81 + 8'(i);
      step();
      chk($sformatf("t4_rd%0d", i), data_out, 8'h80 + 8'(i));
      chk($sformatf("t4_empty%0d", i), empty, 0);
      chk($sformatf("t4_full%0d", i), full, 0);
    end
    write_enb = 1'b0;
    step();
    read_enb = 1'b0;
    chk("t4_last", data_out, 8'hA8);
    chk("t4_empty_end", empty, 1);

    // 5: soft_reset discards a partial packet
    for (int i = 0; i < 5; i++) wr(8'h30 + 8'(i), 1'b0);
    read_enb = 1'b1;
    step(); chk("t5_rd0", data_out, 8'h30);
    step(); chk("t5_rd1", data_out, 8'h31);
    read_enb = 1'b0;
    soft_reset = 1'b1;
    step();
    soft_reset = 1'b0;
    chk("t5_sr_empty", empty, 1);
    chk("t5_sr_full", full, 0);
    chk("t5_sr_dout", data_out, 0);
    wr(8'h55, 1'b0);
    read_enb = 1'b1;
    step();
    read_enb = 1'b0;
    chk("t5_rd55", data_out, 8'h55);
    chk("t5_empty_end", empty, 1);

    // 6: hard reset while a read is requested
    for (int i = 0; i < 3; i++) wr(8'h40 + 8'(i), 1'b0);
    read_enb = 1'b1;
    step();
    chk("t6_rd0", data_out, 8'h40);
    resetn = 1'b0;
    step();
    chk("t6_rst_dout", data_out, 0);
    chk("t6_rst_empty", empty, 1);
    chk("t6_rst_full", full, 0);
    resetn = 1'b1;
    step();
    chk("t6_post_dout", data_out, 0);
    chk("t6_post_empty", empty, 1);
    read_enb = 1'b0;
    wr(8'h99, 1'b0);
    read_enb = 1'b1;
    step();
    read_enb = 1'b0;
    chk("t6_rd99", data_out, 8'h99);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
